// File: rtl/usb_gpx_pkg.sv
// Shared definitions for the MAX3421E GPX event controller: register map,
// control/status bit positions and the filter state encoding.
package usb_gpx_pkg;

    // Avalon-MM word addresses
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_EVCNT  = 2'd3;

    // CTRL register bit positions
    localparam int CTRL_ENABLE_BIT  = 0;
    localparam int CTRL_RISE_IE_BIT = 1;
    localparam int CTRL_FALL_IE_BIT = 2;

    // STATUS register bit positions
    localparam int STATUS_RISE_BIT = 0;
    localparam int STATUS_FALL_BIT = 1;

    // Qualification counter width; covers FILT_CYCLES up to 255
    localparam int FILT_CNT_W = 8;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        QUAL_HI   = 2'd1,
        STABLE_HI = 2'd2,
        QUAL_LO   = 2'd3
    } filt_state_e;

endpackage

// File: rtl/usb_gpx_filter.sv
// Synchronizes the raw GPX pin and qualifies level changes: a new level is
// accepted only after FILT_CYCLES consecutive synchronized samples agree.
// rise_pulse/fall_pulse are high in the cycle whose clock edge flips filt_level.
module usb_gpx_filter
    import usb_gpx_pkg::*;
#(
    parameter int FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic gpx_in,
    output logic filt_level,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILT_CYCLES - 1);

    logic                  s1, s2;
    filt_state_e           state, state_nxt;
    logic [FILT_CNT_W-1:0] cnt, cnt_nxt;
    logic                  level_nxt;

    // Two-flop synchronizer for the asynchronous GPX pin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= gpx_in;
            s2 <= s1;
        end
    end

    // Filter state, qualification counter and accepted level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= STABLE_LO;
            cnt        <= '0;
            filt_level <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            filt_level <= level_nxt;
        end
    end

    // Next-state logic: start, continue, abandon or complete a qualification
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_nxt  = state;
        cnt_nxt    = cnt;
        level_nxt  = filt_level;
        rise_pulse = 1'b0;
        fall_pulse = 1'b0;
        unique case (state)
            STABLE_LO: begin
                if (s2) begin
                    if (FILT_CYCLES == 1) begin
                        state_nxt  = STABLE_HI;
                        level_nxt  = 1'b1;
                        rise_pulse = 1'b1;
                    end else begin
                        state_nxt = QUAL_HI;
                        cnt_nxt   = FILT_CNT_W'(1);
                    end
                end
            end
            QUAL_HI: begin
                if (!s2) begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt  = STABLE_HI;
                    cnt_nxt    = '0;
                    level_nxt  = 1'b1;
                    rise_pulse = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STABLE_HI: begin
                if (!s2) begin
                    if (FILT_CYCLES == 1) begin
                        state_nxt  = STABLE_LO;
                        level_nxt  = 1'b0;
                        fall_pulse = 1'b1;
                    end else begin
                        state_nxt = QUAL_LO;
                        cnt_nxt   = FILT_CNT_W'(1);
                    end
                end
            end
            QUAL_LO: begin
                if (s2) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt  = STABLE_LO;
                    cnt_nxt    = '0;
                    level_nxt  = 1'b0;
                    fall_pulse = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = STABLE_LO;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/usb_gpx_event_ctrl.sv
// GPX event controller: filtered pin level, edge-pending flags with interrupt
// enables, a saturating rising-edge counter, and an Avalon-MM slave with
// fixed read latency of one cycle.
module usb_gpx_event_ctrl
    import usb_gpx_pkg::*;
#(
    parameter int FILT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        gpx_in,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    logic             filt_level, rise_pulse, fall_pulse;
    logic             ctrl_enable, ctrl_rise_ie, ctrl_fall_ie;
    logic             rise_pend, fall_pend;
    logic [CNT_W-1:0] evcnt;
    logic [31:0]      rd_mux;
    logic             wr_ctrl, wr_status, wr_evcnt, rd_en;
    logic             rise_evt, fall_evt;
    logic             wdata_unused;

    usb_gpx_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filter (
        .clk        (clk),
        .reset_n    (reset_n),
        .gpx_in     (gpx_in),
        .filt_level (filt_level),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    assign rd_en        = chipselect & read;
    assign wr_ctrl      = chipselect & write & (address == ADDR_CTRL);
    assign wr_status    = chipselect & write & (address == ADDR_STATUS);
    assign wr_evcnt     = chipselect & write & (address == ADDR_EVCNT);
    assign rise_evt     = rise_pulse & ctrl_enable;
    assign fall_evt     = fall_pulse & ctrl_enable;
    assign wdata_unused = ^writedata[31:3];

    // CTRL register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_enable  <= 1'b0;
            ctrl_rise_ie <= 1'b0;
            ctrl_fall_ie <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_enable  <= writedata[CTRL_ENABLE_BIT];
            ctrl_rise_ie <= writedata[CTRL_RISE_IE_BIT];
            ctrl_fall_ie <= writedata[CTRL_FALL_IE_BIT];
        end
    end

    // STATUS pending bits: write-1-to-clear, a same-cycle event wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_pend <= 1'b0;
            fall_pend <= 1'b0;
        end else begin
            rise_pend <= (rise_pend & ~(wr_status & writedata[STATUS_RISE_BIT])) | rise_evt;
            fall_pend <= (fall_pend & ~(wr_status & writedata[STATUS_FALL_BIT])) | fall_evt;
        end
    end

    // Saturating rising-edge counter; any write clears, a same-cycle event counts as the first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evcnt <= '0;
        end else if (wr_evcnt) begin
            evcnt <= rise_evt ? CNT_W'(1) : '0;
        end else if (rise_evt && !(&evcnt)) begin
            evcnt <= evcnt + 1'b1;
        end
    end

    // Read-data selection; unused bits read as zero
    always_comb begin
        rd_mux = '0;
        unique case (address)
            ADDR_DATA:   rd_mux[0] = filt_level;
            ADDR_CTRL:   begin
                rd_mux[CTRL_ENABLE_BIT]  = ctrl_enable;
                rd_mux[CTRL_RISE_IE_BIT] = ctrl_rise_ie;
                rd_mux[CTRL_FALL_IE_BIT] = ctrl_fall_ie;
            end
            ADDR_STATUS: begin
                rd_mux[STATUS_RISE_BIT] = rise_pend;
                rd_mux[STATUS_FALL_BIT] = fall_pend;
            end
            ADDR_EVCNT:  rd_mux = 32'(evcnt);
            default:     rd_mux = '0;
        endcase
    end

    // Registered read data, zero when no read is being returned
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_en ? rd_mux : '0;
        end
    end

    assign irq = (rise_pend & ctrl_rise_ie) | (fall_pend & ctrl_fall_ie);

endmodule

// File: tb/tb_usb_gpx_event_ctrl.sv
// Self-checking bench for usb_gpx_event_ctrl: directed scenarios followed by
// randomized pin/bus traffic, all compared against a behavioural model.
module tb_usb_gpx_event_ctrl;

    localparam int F = 4;
    localparam int W = 4;
    localparam int CNT_MAX = (1 << W) - 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        gpx_in;
    logic [1:0]  address;
    logic        chipselect, read, write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    usb_gpx_event_ctrl #(.FILT_CYCLES(F), .CNT_W(W)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .gpx_in     (gpx_in),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Behavioural model: pin history, run length of disagreeing samples, registers
    typedef struct packed {
        logic [1:0]  hist;   // pin values seen at the last two edges, [1] is older
        logic        level;
        int          run;
        logic        en, rie, fie, rp, fp;
        int          evcnt;
        logic [31:0] rdata;
    } model_t;

    model_t m;
    logic   m_irq;

    function automatic model_t model_step(model_t cur, logic pin, logic cs, logic rd,
                                          logic wr, logic [1:0] a, logic [31:0] wd);
        model_t nx = cur;
        logic   rise = 1'b0;
        logic   fall = 1'b0;
        // read returns the state as it was before this edge
        nx.rdata = '0;
        if (cs && rd) begin
            case (a)
                2'd0: nx.rdata = {31'b0, cur.level};
                2'd1: nx.rdata = {29'b0, cur.fie, cur.rie, cur.en};
                2'd2: nx.rdata = {30'b0, cur.fp, cur.rp};
                default: nx.rdata = 32'(cur.evcnt);
            endcase
        end
        // a level change is accepted after F consecutive disagreeing samples,
        // where the sample used now is the pin as it stood two edges ago
        if (cur.hist[1] != cur.level) begin
            nx.run = cur.run + 1;
            if (nx.run >= F) begin
                nx.level = cur.hist[1];
                nx.run   = 0;
                rise     = nx.level;
                fall     = !nx.level;
            end
        end else begin
            nx.run = 0;
        end
        nx.hist = {cur.hist[0], pin};
        if (cs && wr) begin
            case (a)
                2'd1: {nx.fie, nx.rie, nx.en} = wd[2:0];
                2'd2: begin
                    if (wd[0]) nx.rp = 1'b0;
                    if (wd[1]) nx.fp = 1'b0;
                end
                2'd3: nx.evcnt = 0;
                default: ;
            endcase
        end
        if (rise && cur.en) begin
            nx.rp    = 1'b1;
            nx.evcnt = (nx.evcnt >= CNT_MAX) ? CNT_MAX : nx.evcnt + 1;
        end
        if (fall && cur.en) nx.fp = 1'b1;
        return nx;
    endfunction

    // Advance the model on every edge, clear it on reset
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= '0;
        else m <= model_step(m, gpx_in, chipselect, read, write, address, writedata);
    end

    assign m_irq = (m.rp & m.rie) | (m.fp & m.fie);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: wait for the falling edge, then compare outputs with the model
    task automatic tick();
        @(negedge clk);
        check("readdata", readdata, m.rdata);
        check("irq", {31'b0, irq}, {31'b0, m_irq});
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write = 1'b0; writedata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1'b1; read = 1'b1; address = a;
        tick();
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    initial begin
        logic [31:0] d;
        int          first;
        int          hold_left;
        int          r;

        reset_n = 1'b0; gpx_in = 1'b0; address = '0;
        chipselect = 1'b0; read = 1'b0; write = 1'b0; writedata = '0;

        // Reset state
        hold(2);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        hold(4);

        // Qualified rising edge with enable and rise_ie: irq after exactly F+1 edges
        bus_write(2'd1, 32'h3);
        hold(6);
        gpx_in = 1'b1;
        for (int i = 0; i < F + 1; i++) begin
            tick();
            check("irq_before_accept", {31'b0, irq}, 32'h0);
        end
        tick();
        check("irq_on_accept", {31'b0, irq}, 32'h1);
        bus_read(2'd0, d);  check("rise_data", d, 32'h1);
        bus_read(2'd2, d);  check("rise_status", d, 32'h1);
        bus_read(2'd3, d);  check("rise_evcnt", d, 32'h1);

        // W1C of rise_pend on the very edge a new rising event is accepted
        gpx_in = 1'b0;
        hold(8);
        gpx_in = 1'b1;
        hold(F + 1);
        bus_write(2'd2, 32'h1);
        check("w1c_race_irq", {31'b0, irq}, 32'h1);
        bus_read(2'd2, d);  check("w1c_race_status", d, 32'h3);
        bus_read(2'd3, d);  check("w1c_race_evcnt", d, 32'h2);

        // Short glitch is rejected
        gpx_in = 1'b0;
        hold(8);
        bus_write(2'd2, 32'h3);
        bus_write(2'd3, 32'h0);
        gpx_in = 1'b1;
        hold(F - 1);
        gpx_in = 1'b0;
        hold(8);
        bus_read(2'd0, d);  check("glitch_data", d, 32'h0);
        bus_read(2'd2, d);  check("glitch_status", d, 32'h0);
        bus_read(2'd3, d);  check("glitch_evcnt", d, 32'h0);
        check("glitch_irq", {31'b0, irq}, 32'h0);

        // Counter saturation and clear-on-write
        for (int i = 0; i < 20; i++) begin
            gpx_in = 1'b1; hold(F + 2);
            gpx_in = 1'b0; hold(F + 2);
        end
        bus_read(2'd3, d);  check("evcnt_saturated", d, 32'(CNT_MAX));
        bus_write(2'd3, 32'hDEAD_BEEF);
        bus_read(2'd3, d);  check("evcnt_cleared", d, 32'h0);

        // Disabled: DATA still tracks, no events; CTRL readback and ignored writes
        bus_write(2'd1, 32'h0);
        bus_write(2'd2, 32'h3);
        gpx_in = 1'b1; hold(F + 2);
        bus_read(2'd0, d);  check("disabled_data_hi", d, 32'h1);
        gpx_in = 1'b0; hold(F + 2);
        bus_read(2'd0, d);  check("disabled_data_lo", d, 32'h0);
        bus_read(2'd2, d);  check("disabled_status", d, 32'h0);
        bus_read(2'd3, d);  check("disabled_evcnt", d, 32'h0);
        bus_write(2'd1, 32'hFFFF_FFF8);
        bus_read(2'd1, d);  check("ctrl_unused_bits", d, 32'h0);
        bus_write(2'd1, 32'h7);
        bus_read(2'd1, d);  check("ctrl_readback", d, 32'h7);
        tick();
        check("readdata_idle", readdata, 32'h0);
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_read(2'd1, d);  check("data_write_ignored", d, 32'h7);

        // Reset in the middle of a qualification with the pin high
        gpx_in = 1'b1;
        hold(3);
        reset_n = 1'b0;
        tick();
        check("midq_reset_readdata", readdata, 32'h0);
        check("midq_reset_irq", {31'b0, irq}, 32'h0);
        hold(2);
        reset_n = 1'b1;
        first = -1;
        for (int i = 0; i < 20; i++) begin
            bus_read(2'd0, d);
            if (first < 0 && d[0]) first = i;
        end
        check("post_reset_latency", 32'(first), 32'(F + 2));
        bus_read(2'd1, d);  check("post_reset_ctrl", d, 32'h0);
        bus_read(2'd2, d);  check("post_reset_status", d, 32'h0);
        bus_read(2'd3, d);  check("post_reset_evcnt", d, 32'h0);

        // Randomized pin activity and bus traffic
        bus_write(2'd1, 32'h7);
        hold_left = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold_left == 0) begin
                gpx_in    = 1'($urandom_range(0, 1));
                hold_left = $urandom_range(1, 2 * F + 1);
            end
            hold_left--;
            r = $urandom_range(0, 9);
            address = 2'($urandom_range(0, 3));
            if (r < 3) begin
                chipselect = 1'b1; read = 1'b1;
            end else if (r == 3) begin
                chipselect = 1'b1; write = 1'b1;
                writedata  = $urandom;
                if (address == 2'd1) writedata[0] = ($urandom_range(0, 7) != 0);
            end else if (r == 4) begin
                chipselect = 1'b0; read = 1'b1; write = 1'b1; writedata = $urandom;
            end
            tick();
            chipselect = 1'b0; read = 1'b0; write = 1'b0; writedata = '0;
        end
        hold(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_gpx_event_ctrl.md
USB_GPX_EVENT_CTRL -- requirements
Module: usb_gpx_event_ctrl

Interface
REQ-001 SHALL have parameter: FILT_CYCLES, 4, consecutive synchronized samples required to accept a GPX level change (legal 1..255).
REQ-002 SHALL have parameter: CNT_W, 16, width of the rising-edge event counter (legal 1..32).
REQ-003 SHALL have port: clk  in  1  system clock.
REQ-004 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port: gpx_in  in  1  raw MAX3421E GPX pin, asynchronous to clk.
REQ-006 SHALL have ports: address  in  2 (Avalon-MM word address); chipselect  in  1; read  in  1; write  in  1.
REQ-007 SHALL have port: writedata  in  32  Avalon-MM write data.
REQ-008 SHALL have port: readdata  out  32  registered Avalon-MM read data.
REQ-009 SHALL have port: irq  out  1  level interrupt to CPU, active-high.

Function
REQ-010 SHALL pass gpx_in through a two-flop synchronizer (s1, s2) before any other use.
REQ-011 SHALL run a filter FSM with states STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO and a qualification counter.
- STABLE_LO: s2=1 -> QUAL_HI, cnt=1. STABLE_HI: s2=0 -> QUAL_LO, cnt=1.
- QUAL_x: s2 reverts -> back to STABLE state, cnt=0; s2 holds and cnt=FILT_CYCLES-1 -> opposite STABLE state, filt_level toggles; else cnt+1.
- FILT_CYCLES=1: STABLE state SHALL go straight to the opposite STABLE state.
REQ-012 SHALL toggle filt_level at edge N+1+FILT_CYCLES when gpx_in changes before edge N and then holds.
REQ-013 SHALL ignore pulses shorter than FILT_CYCLES cycles (after synchronization): no filt_level change, no event.
REQ-014 SHALL provide the register map:
- 0 DATA (RO): bit0 = filt_level.
- 1 CTRL (RW): bit0 enable, bit1 rise_ie, bit2 fall_ie.
- 2 STATUS (W1C): bit0 rise_pend, bit1 fall_pend.
- 3 EVCNT (RO, any write clears): CNT_W-bit rising-edge count.
- Unused bits SHALL read 0.
REQ-015 SHALL set rise_pend/fall_pend on the same edge filt_level goes 0->1 / 1->0, only when enable=1.
REQ-016 SHALL give set priority over a same-cycle W1C clear of the same bit.
REQ-017 SHALL increment EVCNT on each rising filtered edge while enable=1 and saturate at all-ones.
REQ-018 SHALL load EVCNT=1 on a same-cycle EVCNT write and rising event; write alone -> 0.
REQ-019 SHALL keep the filter and DATA tracking while enable=0; clearing enable SHALL NOT clear pending bits or EVCNT.
REQ-020 SHALL drive irq = (rise_pend & rise_ie) | (fall_pend & fall_ie), from registers only, with no combinational path from bus inputs.
REQ-021 SHALL register readdata one cycle after chipselect&read (fixed read latency 1, no waitrequest); readdata SHALL be 0 otherwise.
REQ-022 SHALL accept writes only when chipselect&write; writes to address 0 SHALL be ignored.

Reset
REQ-023 SHALL, on reset_n low, asynchronously clear: s1, s2, filt_level, cnt, CTRL, STATUS, EVCNT, readdata; FSM -> STABLE_LO; irq=0.
REQ-024 SHALL abandon any in-progress qualification on reset; if gpx_in is high after release, filt_level SHALL rise after the normal latency with no event (enable=0).

Structure
REQ-025 SHALL place register address constants, CTRL/STATUS bit positions and the filter state enum in shared package usb_gpx_pkg.
REQ-026 SHALL implement the synchronizer, filter FSM and counter as sub-module usb_gpx_filter (outputs filt_level, rise_pulse, fall_pulse); the top holds registers, bus decode and irq.

Verification
REQ-027 SHALL cover: FILT_CYCLES=4, enable=1, rise_ie=1, gpx_in 0->1 held -> filt_level=1 at edge N+5, rise_pend=1, irq=1, EVCNT=1.
REQ-028 SHALL cover: 3-cycle high glitch on gpx_in -> DATA stays 0, STATUS=0, EVCNT=0, irq=0.
REQ-029 SHALL cover: write STATUS=0x1 on the same cycle a new rising event is accepted -> rise_pend stays 1, irq stays 1.
REQ-030 SHALL cover: CNT_W=4, 20 qualified rising edges -> EVCNT reads 0xF; write EVCNT -> reads 0.
REQ-031 SHALL cover: enable=0, toggle gpx_in -> DATA follows, STATUS=0, EVCNT=0; read CTRL after writing 0x7 -> 0x7 one cycle after read.
REQ-032 SHALL cover: assert reset_n low mid-qualification with gpx_in high -> all registers 0, irq=0; after release DATA=1 at release+1+FILT_CYCLES+1, STATUS=0.
